execution_scheduler: RTL



---
 rtl/dragonfang_pkg.sv | 22 ++
 rtl/riscv_v_pkg.sv | 11 +
 rtl/round_robin_arbiter.sv | 27 ++
 rtl/execution_scheduler.sv | 121 ++++++++++++
 4 files changed

// File: rtl/dragonfang_pkg.sv
// Core-wide sizing for the vector back end plus the tag types derived from it.
package dragonfang_pkg;

    localparam int NUMBER_FUNCTIONAL_UNITS   = 2;
    localparam int NUMBER_PHYSICAL_REGISTERS = 32;
    localparam int EXECUTION_LATENCY         = 3;

    localparam int FU_TAG_W  = (NUMBER_FUNCTIONAL_UNITS > 1) ? $clog2(NUMBER_FUNCTIONAL_UNITS) : 1;
    localparam int VRG_TAG_W = $clog2(NUMBER_PHYSICAL_REGISTERS);
    localparam int FU_CNT_W  = $clog2(EXECUTION_LATENCY + 1);

    typedef logic [FU_TAG_W-1:0]                  fu_tag_t;
    typedef logic [VRG_TAG_W-1:0]                 vrg_tag_t;
    typedef logic [FU_CNT_W-1:0]                  fu_cnt_t;
    typedef logic [NUMBER_PHYSICAL_REGISTERS-1:0] vrg_mask_t;
    typedef logic [NUMBER_FUNCTIONAL_UNITS-1:0]   fu_mask_t;

    function automatic vrg_mask_t vrg_onehot(input vrg_tag_t tag);
        return vrg_mask_t'(1) << tag;
    endfunction

endpackage

// File: rtl/riscv_v_pkg.sv
// Vector ISA types shared with the decode and execution blocks.
package riscv_v_pkg;

    typedef struct packed {
        logic [5:0] funct6;
        logic [2:0] funct3;
        logic       vm;
        logic [2:0] vsew;
    } execution_vector_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick of a free functional unit, searching upward from pointer.
module round_robin_arbiter
    import dragonfang_pkg::*;
(
    input  fu_mask_t free_mask,
    input  fu_tag_t  pointer,
    output fu_tag_t  grant,
    output logic     grant_valid
);

    int idx;

    // Walk the search order backwards so the unit closest to the pointer is assigned last and wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = NUMBER_FUNCTIONAL_UNITS - 1; i >= 0; i--) begin
            idx = (int'(pointer) + i) % NUMBER_FUNCTIONAL_UNITS;
            if (free_mask[idx]) begin
                grant       = fu_tag_t'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/execution_scheduler.sv
// In-order vector issue controller with register scoreboard and per-unit occupancy counters.
// Define SCOREBOARD_BYPASS_EN to let retiring registers/units satisfy the hazard check in the same cycle.
module execution_scheduler
    import dragonfang_pkg::*;
    import riscv_v_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  execution_vector_t instr_vector,
    input  vrg_tag_t          instr_vs1_tag,
    input  vrg_tag_t          instr_vs2_tag,
    input  vrg_tag_t          instr_vd_tag,
    output logic              issue_valid,
    output execution_vector_t execution_vector,
    output fu_tag_t           functional_unit_tag,
    output vrg_tag_t          destination_vrg_tag,
    output vrg_tag_t          vs1_tag,
    output vrg_tag_t          vs2_tag,
    output logic              writeback_valid,
    output vrg_tag_t          writeback_tag,
    output vrg_mask_t         busy_mask
);

    vrg_mask_t busy;
    fu_cnt_t   cnt  [NUMBER_FUNCTIONAL_UNITS];
    vrg_tag_t  dest [NUMBER_FUNCTIONAL_UNITS];
    fu_tag_t   rr;

    fu_mask_t  free_mask;
    vrg_mask_t retire_mask;
    vrg_mask_t hazard_mask;
    fu_tag_t   grant;
    logic      grant_valid;
    logic      handshake;

    // Equal latencies and single issue guarantee at most one unit sits at count 1.
    always_comb begin
        writeback_valid = 1'b0;
        writeback_tag   = '0;
        for (int f = 0; f < NUMBER_FUNCTIONAL_UNITS; f++) begin
            if (cnt[f] == fu_cnt_t'(1)) begin
                writeback_valid = 1'b1;
                writeback_tag   = dest[f];
            end
        end
        retire_mask = writeback_valid ? vrg_onehot(writeback_tag) : '0;
    end

    always_comb begin
        free_mask = '0;
`ifdef SCOREBOARD_BYPASS_EN
        for (int f = 0; f < NUMBER_FUNCTIONAL_UNITS; f++)
            free_mask[f] = (cnt[f] <= fu_cnt_t'(1));
        hazard_mask = busy & ~retire_mask;
`else
        for (int f = 0; f < NUMBER_FUNCTIONAL_UNITS; f++)
            free_mask[f] = (cnt[f] == '0);
        hazard_mask = busy;
`endif
    end

    round_robin_arbiter u_arbiter (
        .free_mask   (free_mask),
        .pointer     (rr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign instr_ready = !hazard_mask[instr_vs1_tag] && !hazard_mask[instr_vs2_tag]
                      && !hazard_mask[instr_vd_tag] && grant_valid;
    assign handshake   = instr_valid && instr_ready;
    assign busy_mask   = busy;

    // A new destination set overrides a same-cycle retirement of that register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
            rr   <= '0;
            for (int f = 0; f < NUMBER_FUNCTIONAL_UNITS; f++) begin
                cnt[f]  <= '0;
                dest[f] <= '0;
            end
        end else begin
            busy <= (busy & ~retire_mask) | (handshake ? vrg_onehot(instr_vd_tag) : '0);
            for (int f = 0; f < NUMBER_FUNCTIONAL_UNITS; f++) begin
                if (handshake && grant == fu_tag_t'(f)) begin
                    cnt[f]  <= fu_cnt_t'(EXECUTION_LATENCY);
                    dest[f] <= instr_vd_tag;
                end else if (cnt[f] != '0) begin
                    cnt[f] <= cnt[f] - fu_cnt_t'(1);
                end
            end
            if (handshake)
                rr <= (grant == fu_tag_t'(NUMBER_FUNCTIONAL_UNITS - 1)) ? '0 : grant + fu_tag_t'(1);
        end
    end

    // Issue stage: operands and unit grant registered toward execution and the VRG read port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid         <= 1'b0;
            execution_vector    <= '0;
            functional_unit_tag <= '0;
            destination_vrg_tag <= '0;
            vs1_tag             <= '0;
            vs2_tag             <= '0;
        end else begin
            issue_valid <= handshake;
            if (handshake) begin
                execution_vector    <= instr_vector;
                functional_unit_tag <= grant;
                destination_vrg_tag <= instr_vd_tag;
                vs1_tag             <= instr_vs1_tag;
                vs2_tag             <= instr_vs2_tag;
            end
        end
    end

endmodule
